// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, owner
// encoding, default bus widths and the fixed-priority-with-fairness pick.
package mem_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // On a tie, the requester that was not served last wins.
  function automatic owner_e pick_owner(input logic i_req, input logic d_req,
                                        input owner_e last_grant);
    if (i_req && d_req) return (last_grant == OWN_I) ? OWN_D : OWN_I;
    else if (d_req)     return OWN_D;
    else                return OWN_I;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles spent waiting on memory; expired flags the final
// allowed wait cycle so the arbiter can abort on that edge.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clrn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear)                    count_d = '0;
    else if (enable && !expired)  count_d = count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clrn) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory bus with a bounded
// wait: IDLE grants, BUSY waits for m_ready or timeout, ACK pulses the ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          bus_err,
  output logic          stall
);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d, last_grant_q, last_grant_d, grant_owner;
  logic          m_req_q, m_req_d, m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          i_ack_q, i_ack_d, d_ack_q, d_ack_d, bus_err_q, bus_err_d;
  logic          any_req, tmo_expired;

  assign any_req     = i_req | d_req;
  assign grant_owner = pick_owner(i_req, d_req, last_grant_q);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .clrn    (clrn),
    .clear   ((state_q == ST_IDLE) && any_req),
    .enable  ((state_q == ST_BUSY) && !m_ready),
    .expired (tmo_expired)
  );

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_BUSY;
          owner_d      = grant_owner;
          last_grant_d = grant_owner;
          m_req_d      = 1'b1;
          if (grant_owner == OWN_D) begin
            m_addr_d  = d_addr;
            m_we_d    = d_we;
            m_wdata_d = d_wdata;
          end else begin
            m_addr_d  = i_addr;
            m_we_d    = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        // m_ready wins over a coincident timeout: the data is genuine.
        if (m_ready || tmo_expired) begin
          state_d   = ST_ACK;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          bus_err_d = !m_ready;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = m_ready ? m_rdata : '0;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_ready ? m_rdata : '0;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign bus_err = bus_err_q;
  assign stall   = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter TIMEOUT, default 15: maximum BUSY cycles without m_ready before abort.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 clrn  in  1  reset, synchronous, active-low.
REQ-006 i_req  in  1  instruction-fetch request, level, held until i_ack.
REQ-007 i_addr  in  AW  fetch address.
REQ-008 i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 i_rdata  out  DW  fetched word, valid while i_ack=1.
REQ-010 d_req  in  1  data-access request, level, held until d_ack.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  AW  data address.
REQ-013 d_wdata  in  DW  store data.
REQ-014 d_ack  out  1  one-cycle data completion pulse.
REQ-015 d_rdata  out  DW  load data, valid while d_ack=1.
REQ-016 m_req  out  1  memory request, high in every BUSY cycle.
REQ-017 m_we  out  1  memory write enable.
REQ-018 m_addr  out  AW  memory address.
REQ-019 m_wdata  out  DW  memory write data.
REQ-020 m_rdata  in  DW  memory read data, valid with m_ready.
REQ-021 m_ready  in  1  memory completion strobe.
REQ-022 bus_err  out  1  one-cycle pulse, coincident with the ack of an aborted transaction.
REQ-023 stall  out  1  pipeline stall = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.

Function
REQ-024 FSM states: IDLE, BUSY, ACK; all outputs except stall are registered.
REQ-025 IDLE: if exactly one request is active, grant it; if both, grant the requester not in last_grant; if none, stay in IDLE.
REQ-026 On grant: latch owner, address, we, and wdata into internal registers; go to BUSY; set last_grant to owner.
REQ-027 BUSY: m_req=1; m_addr/m_we/m_wdata come from the latched registers and stay stable; fetches drive m_we=0.
REQ-028 BUSY with m_ready=1: capture m_rdata into the owner's rdata register; go to ACK.
REQ-029 ACK: owner's ack=1 for exactly one cycle; m_req=0; next state IDLE unconditionally.
REQ-030 Latency: request seen in IDLE cycle N, m_ready in cycle N+1 gives ack in cycle N+2; minimum back-to-back spacing is 3 cycles.
REQ-031 Wait counter: cleared on grant; increments each BUSY cycle without m_ready.
REQ-032 If the counter reaches TIMEOUT-1 in a BUSY cycle without m_ready: go to ACK; rdata = 0; bus_err=1 during the ACK cycle.
REQ-033 m_ready in IDLE or ACK is ignored.
REQ-034 If a requester drops its request during BUSY, the transaction still completes and the ack is still pulsed.
REQ-035 Request inputs are not resampled in BUSY or ACK.
REQ-036 i_ack and d_ack are never high together.
REQ-037 rdata registers hold their value between acks.

Reset
REQ-038 When clrn=0 at a rising edge, the next state is IDLE from any state, including mid-BUSY; no ack is issued for the dropped transaction.
REQ-039 Reset values: m_req=0, m_we=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, bus_err=0, wait counter=0, last_grant=I.
REQ-040 last_grant=I at reset, so D wins the first simultaneous request.

Structure
REQ-041 The shared package holds: state encodings (IDLE/BUSY/ACK, 2 bits), owner encoding (OWN_I=0, OWN_D=1), and AW/DW default constants.
REQ-042 The wait counter is a sub-module, mem_timeout_ctr: inputs clear and enable, output expired; width clog2(TIMEOUT).

Verification
REQ-043 clrn=0 for 2 cycles with i_req=1 -> m_req=0, i_ack=0, stall=1; first grant 1 cycle after clrn=1.
REQ-044 i_req with i_addr=0x00000040; m_ready=1 in first BUSY cycle with m_rdata=0x20080005 -> m_req high 1 cycle with m_addr=0x40 and m_we=0; i_ack two cycles after request; i_rdata=0x20080005.
REQ-045 i_req and d_req both asserted at reset exit; d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> D served first (m_we=1, m_wdata=0xDEADBEEF), then I; acks 3 cycles apart.
REQ-046 Both requests held through 4 transactions, memory 1-wait -> service order D, I, D, I; no overlap of acks.
REQ-047 TIMEOUT=15 with m_ready never asserted on a D load -> m_req high 15 cycles, then d_ack=1 with bus_err=1 and d_rdata=0; next grant proceeds normally.
REQ-048 clrn=0 in the 2nd BUSY cycle of a fetch -> next cycle IDLE, m_req=0, no i_ack; fetch re-granted after clrn=1.
